// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage feeding the priority D flip-flop.
// A WIDTH-bit word is taken over a valid/ready handshake in IDLE.
// It is shifted out MSB-first on sout, one bit per shift_en cycle.
// After the last bit, done pulses for one cycle and the block returns to IDLE.
// clr (async, active-high) outranks pre (async, active-low), which outranks normal operation.
// Optional macro PARITY_EN: the even parity of the captured word is sent as one extra bit
// from a PAR state after the data bits.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef PARITY_EN
    logic               par_q, par_d;
`endif

    // State and datapath registers; clr outranks pre, and both act asynchronously.
    always_ff @(posedge clk or posedge clr or negedge pre) begin
        if (clr) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (!pre) begin
            state_q <= S_IDLE;
            shreg_q <= '1;
            cnt_q   <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, shift and handshake logic; all outputs are decoded from registers only.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
`ifdef PARITY_EN
        par_d     = par_q;
`endif
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sout      = 1'b1;

        case (state_q)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = '0;
`ifdef PARITY_EN
                    par_d   = ^din;
`endif
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                busy = 1'b1;
                sout = shreg_q[WIDTH-1];
                if (shift_en) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end

`ifdef PARITY_EN
            S_PAR: begin
                busy = 1'b1;
                sout = par_q;
                if (shift_en) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: self-checking bench for piso_serializer.
// Expected serial streams come from a queue model: the word's bits MSB-first,
// plus the even-parity bit when PARITY_EN is defined.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk;
    logic         clr;
    logic         pre;
    logic         din_valid;
    logic [W-1:0] din;
    logic         din_ready;
    logic         shift_en;
    logic         sout;
    logic         busy;
    logic         done;

    int vectors;
    int miscompares;

    piso_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .pre       (pre),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .shift_en  (shift_en),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #1;
        vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (sout !== 1'b1) begin miscompares++; $display("FAIL reset_sout got=%b exp=1", sout); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        tick();
        clr = 1'b0;
        tick();
        vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got=%b exp=1", din_ready); end
    endtask

    // A5 with shift_en held high: one bit per cycle, then a single done cycle.
    task automatic test_steady();
        logic [W-1:0] word;
        bit q[$];
        word = 8'hA5;
        for (int b = W - 1; b >= 0; b--) q.push_back(word[b]);
`ifdef PARITY_EN
        q.push_back(^word);
`endif
        din = word; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            vectors++; if (sout !== q[i]) begin miscompares++; $display("FAIL steady_bit%0d got=%b exp=%b", i, sout, q[i]); end
            vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL steady_busy%0d busy=%b done=%b exp busy=1 done=0", i, busy, done); end
            tick();
        end
        shift_en = 1'b0;
        vectors++; if (done !== 1'b1 || busy !== 1'b0 || sout !== 1'b1 || din_ready !== 1'b0) begin
            miscompares++; $display("FAIL steady_done done=%b busy=%b sout=%b ready=%b exp 1/0/1/0", done, busy, sout, din_ready); end
        tick();
        vectors++; if (done !== 1'b0 || din_ready !== 1'b1) begin miscompares++; $display("FAIL steady_idle done=%b ready=%b exp 0/1", done, din_ready); end
    endtask

    // C3 with shift_en alternating: every bit must hold through its stall cycle.
    task automatic test_stall();
        logic [W-1:0] word;
        bit q[$];
        word = 8'hC3;
        for (int b = W - 1; b >= 0; b--) q.push_back(word[b]);
`ifdef PARITY_EN
        q.push_back(^word);
`endif
        din = word; din_valid = 1'b1; shift_en = 1'b0;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            vectors++; if (sout !== q[i]) begin miscompares++; $display("FAIL stall_bit%0d got=%b exp=%b", i, sout, q[i]); end
            shift_en = 1'b0;
            tick();
            vectors++; if (sout !== q[i] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold%0d sout=%b busy=%b done=%b exp %b/1/0", i, sout, busy, done, q[i]); end
            shift_en = 1'b1;
            tick();
        end
        shift_en = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got=%b exp=1", done); end
        tick();
        vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL stall_idle got=%b exp=1", din_ready); end
    endtask

    // clr in the middle of a word discards it: immediate IDLE and no done afterwards.
    task automatic test_clr_midshift();
        din = 8'hA5; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        din_valid = 1'b0;
        tick(); tick(); tick();
        vectors++; if (sout !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL clrmid_pre sout=%b busy=%b exp 0/1", sout, busy); end
        clr = 1'b1;
        #1;
        vectors++; if (din_ready !== 1'b1 || sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL clrmid_async ready=%b sout=%b busy=%b done=%b exp 1/1/0/0", din_ready, sout, busy, done); end
        tick();
        clr = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            vectors++; if (done !== 1'b0 || din_ready !== 1'b1 || sout !== 1'b1) begin
                miscompares++; $display("FAIL clrmid_after%0d done=%b ready=%b sout=%b exp 0/1/1", i, done, din_ready, sout); end
        end
        shift_en = 1'b0;
    endtask

    // Preset loads ones, clr overrides it with zeros; preset mid-word also aborts the word.
    task automatic test_preset();
        pre = 1'b0;
        #1;
        vectors++; if (dut.shreg_q !== 8'hFF || sout !== 1'b1 || din_ready !== 1'b1) begin
            miscompares++; $display("FAIL preset_idle shreg=%h sout=%b ready=%b exp ff/1/1", dut.shreg_q, sout, din_ready); end
        tick();
        vectors++; if (dut.shreg_q !== 8'hFF) begin miscompares++; $display("FAIL preset_held shreg=%h exp=ff", dut.shreg_q); end
        clr = 1'b1;
        #1;
        vectors++; if (dut.shreg_q !== 8'h00 || sout !== 1'b1) begin miscompares++; $display("FAIL clr_over_pre shreg=%h sout=%b exp 00/1", dut.shreg_q, sout); end
        clr = 1'b0; pre = 1'b1;
        tick();
        vectors++; if (dut.shreg_q !== 8'h00 || din_ready !== 1'b1) begin miscompares++; $display("FAIL preset_release shreg=%h ready=%b exp 00/1", dut.shreg_q, din_ready); end
        din = 8'h5A; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        pre = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || din_ready !== 1'b1 || sout !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL preset_mid busy=%b ready=%b sout=%b done=%b exp 0/1/1/0", busy, din_ready, sout, done); end
        tick();
        pre = 1'b1; shift_en = 1'b0;
        tick();
        vectors++; if (done !== 1'b0 || din_ready !== 1'b1) begin miscompares++; $display("FAIL preset_after done=%b ready=%b exp 0/1", done, din_ready); end
    endtask

    // din_valid held high with din changing: only IDLE captures, giving W+2 cycles per word.
    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        bit q1[$];
        bit q2[$];
        w1 = W'($urandom); w2 = W'($urandom);
        for (int b = W - 1; b >= 0; b--) begin q1.push_back(w1[b]); q2.push_back(w2[b]); end
`ifdef PARITY_EN
        q1.push_back(^w1); q2.push_back(^w2);
`endif
        din = w1; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        for (int i = 0; i < q1.size(); i++) begin
            vectors++; if (sout !== q1[i] || din_ready !== 1'b0) begin
                miscompares++; $display("FAIL b2b_w1_bit%0d sout=%b ready=%b exp %b/0", i, sout, din_ready, q1[i]); end
            din = W'($urandom);
            tick();
        end
        din = w2;
        vectors++; if (done !== 1'b1 || din_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_done done=%b ready=%b exp 1/0", done, din_ready); end
        tick();
        vectors++; if (din_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle ready=%b busy=%b exp 1/0", din_ready, busy); end
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < q2.size(); i++) begin
            vectors++; if (sout !== q2[i] || busy !== 1'b1) begin
                miscompares++; $display("FAIL b2b_w2_bit%0d sout=%b busy=%b exp %b/1", i, sout, busy, q2[i]); end
            tick();
        end
        shift_en = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done2 got=%b exp=1", done); end
        tick();
        vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle2 got=%b exp=1", din_ready); end
    endtask

    // Random words, random shift_en stalls, random din_valid/din noise while busy.
    task automatic test_random(input int nwords);
        logic [W-1:0] word;
        bit q[$];
        int idx;
        int guard;
        for (int w = 0; w < nwords; w++) begin
            q.delete();
            word = W'($urandom);
            for (int b = W - 1; b >= 0; b--) q.push_back(word[b]);
`ifdef PARITY_EN
            q.push_back(^word);
`endif
            vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_ready got=%b exp=1", w, din_ready); end
            din = word; din_valid = 1'b1; shift_en = 1'($urandom_range(0, 1));
            tick();
            din_valid = 1'b0;
            idx = 0; guard = 0;
            while (idx < q.size() && guard < 200) begin
                vectors++; if (sout !== q[idx] || busy !== 1'b1 || done !== 1'b0 || din_ready !== 1'b0) begin
                    miscompares++; $display("FAIL rnd%0d_bit%0d sout=%b busy=%b done=%b ready=%b exp %b/1/0/0", w, idx, sout, busy, done, din_ready, q[idx]); end
                shift_en  = 1'($urandom_range(0, 1));
                din_valid = 1'($urandom_range(0, 1));
                din       = W'($urandom);
                tick();
                if (shift_en) idx++;
                guard++;
            end
            if (guard >= 200) begin
                vectors++; miscompares++; $display("FAIL rnd%0d_timeout bits=%0d exp=%0d", w, idx, q.size());
            end
            shift_en = 1'b0; din_valid = 1'b0;
            vectors++; if (done !== 1'b1 || busy !== 1'b0 || sout !== 1'b1) begin
                miscompares++; $display("FAIL rnd%0d_done done=%b busy=%b sout=%b exp 1/0/1", w, done, busy, sout); end
            tick();
            vectors++; if (done !== 1'b0 || din_ready !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_idle done=%b ready=%b exp 0/1", w, done, din_ready); end
        end
    endtask

`ifdef PARITY_EN
    // 07 carries three ones (parity bit 1), 03 carries two (parity bit 0).
    task automatic test_parity();
        logic [W-1:0] words [2];
        logic         pbits [2];
        words[0] = 8'h07; pbits[0] = 1'b1;
        words[1] = 8'h03; pbits[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din = words[k]; din_valid = 1'b1; shift_en = 1'b1;
            tick();
            din_valid = 1'b0;
            for (int b = W - 1; b >= 0; b--) begin
                vectors++; if (sout !== words[k][b]) begin miscompares++; $display("FAIL par%0d_bit%0d got=%b exp=%b", k, b, sout, words[k][b]); end
                tick();
            end
            vectors++; if (sout !== pbits[k] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++; $display("FAIL par%0d_pbit sout=%b busy=%b done=%b exp %b/1/0", k, sout, busy, done, pbits[k]); end
            tick();
            shift_en = 1'b0;
            vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL par%0d_done got=%b exp=1", k, done); end
            tick();
        end
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        clr = 1'b1; pre = 1'b1; din_valid = 1'b0; din = '0; shift_en = 1'b0;
        test_reset();
        test_steady();
        test_stall();
        test_clr_midshift();
        test_preset();
        test_back_to_back();
        test_random(40);
`ifdef PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
